mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, sets the maximum number of WAIT cycles before a bus request is aborted.
REQ-002 iCLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 iRST  in  1  asynchronous, active-high reset.
REQ-004 iMemRead, iMemWrite  in  1 each  levels from the multicycle control FSM.
REQ-005 iIouD  in  1  address select: 0 selects iPC, 1 selects iALUAddr.
REQ-006 iPC, iALUAddr, iWriteData  in  32 each  fetch address, data address and store data.
REQ-007 iFunct3  in  3  access size and sign for data accesses; ignored when iIouD=0.
REQ-008 oBusAddr, oBusWData  out  32 each; oBusBE  out  4; oBusRead, oBusWrite  out  1 each: memory request side.
REQ-009 iBusRData  in  32; iBusAck  in  1: memory response side.
REQ-010 oLoadData  out  32  combinationally formatted iBusRData, for the IR and the MDR.
REQ-011 oMDR  out  32  registered formatted load data.
REQ-012 oDone  out  1  one-cycle completion pulse; oBusy  out  1  high in WAIT; oBusErr  out  1  sticky timeout flag.

Function
REQ-013 A request SHALL start only on a 0->1 edge of (iMemRead|iMemWrite), detected against a registered copy, so that multi-state assertions by the control FSM produce a single bus transaction.
REQ-014 FSM states SHALL be IDLE, WAIT and DONE: IDLE->WAIT on a request edge; WAIT->DONE on iBusAck; WAIT->IDLE on timeout; DONE->IDLE unconditionally.
REQ-015 In the edge cycle, the bus request SHALL be driven combinationally from the live inputs; address, data, BE and direction SHALL be captured and held from registers throughout WAIT.
REQ-016 If iMemRead and iMemWrite are both high on the edge, the read SHALL win and the write SHALL be dropped.
REQ-017 Fetch accesses (iIouD=0) SHALL be word reads with oBusBE=4'b1111.
REQ-018 Stores SHALL set BE as follows: SB -> one lane selected by addr[1:0], with data replicated to all 4 bytes; SH -> lanes 1:0 or 3:2 selected by addr[1], with the halfword replicated; SW -> 4'b1111.
REQ-019 Loads SHALL extract the lane from the captured addr[1:0]: LB and LH sign-extend, LBU and LHU zero-extend, LW passes through; other funct3 values SHALL behave as LW.
REQ-020 On iBusAck in WAIT, oMDR SHALL load oLoadData for reads and hold for writes; oDone SHALL be high during DONE.
REQ-021 With a sync memory that acks in the first WAIT cycle, data SHALL be valid on oLoadData in the second cycle of the control state pair and on oMDR in the cycle after.
REQ-022 The wait counter SHALL clear on entry to WAIT; when TIMEOUT_CYCLES is reached without iBusAck, the unit SHALL deassert the bus, set oBusErr and return to IDLE.
REQ-023 oBusErr SHALL clear on the next request edge.
REQ-024 A request edge arriving in WAIT or DONE SHALL be ignored.

Reset
REQ-025 iRST SHALL immediately force IDLE and zero every output, the edge register, the wait counter and oMDR, including mid-transaction; the first request after release SHALL require a fresh edge.

Configuration
REQ-026 Macro MISALIGN_TRAP_EN: when defined, a misaligned data access (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL raise no bus request, SHALL set the sticky output oMisaligned (cleared on the next request edge), and SHALL pulse oDone in the following cycle.
REQ-027 When MISALIGN_TRAP_EN is undefined, the port oMisaligned SHALL be absent and the offending low address bits SHALL be forced to zero.

Structure
REQ-028 The funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW) and the FSM state encodings SHALL reside in the shared parameter include file, alongside the existing opcode constants.
REQ-029 Lane extraction and extension SHALL be a combinational sub-module named load_formatter.

Verification
REQ-030 Fetch: iMemRead 0->1 with iIouD=0 and iPC=0x0040_0010, ack in the first WAIT cycle with RData=0x0051_0513 -> exactly one oBusRead, BE=1111, oLoadData=0x0051_0513, one oDone pulse.
REQ-031 LB at iALUAddr=0x1003, RData=0x80AA_BBCC -> oMDR=0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
REQ-032 SH at 0x1002 with iWriteData=0x0000_1234 -> oBusBE=1100, oBusWData=0x1234_1234, oBusWrite held until ack.
REQ-033 No ack for 15 WAIT cycles -> bus deasserted, oBusErr=1, state IDLE; the next request edge clears oBusErr.
REQ-034 iRST pulse in the second WAIT cycle -> all outputs 0 immediately; a held iMemRead after release starts no transaction.
REQ-035 With MISALIGN_TRAP_EN defined, LW at 0x1001 -> no bus request, oMisaligned=1, one oDone pulse.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared constants for the memory access unit of the multicycle core:
//   opcode constants, load/store funct3 encodings, FSM state encoding,
//   access-size type and small lane helpers used by the request datapath.
//   No ports (package).
package mem_access_unit_pkg;

  // Opcode constants of the multicycle core.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Load / store funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Bus handshake FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } stateT;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } sizeT;

  // funct3[1:0] carries the size for both loads and stores; every
  // unlisted encoding is treated as a word access.
  function automatic sizeT accessSize(input logic [2:0] funct3);
    sizeT sz;
    case (funct3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic isMisaligned(input sizeT sz, input logic [1:0] off);
    logic mis;
    case (sz)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Low address bits after forcing natural alignment.
  function automatic logic [1:0] alignOffset(input sizeT sz, input logic [1:0] off);
    logic [1:0] aligned;
    case (sz)
      SZ_HALF: aligned = {off[1], 1'b0};
      SZ_WORD: aligned = 2'b00;
      default: aligned = off;
    endcase
    return aligned;
  endfunction

  function automatic logic [3:0] laneMask(input sizeT sz, input logic [1:0] off);
    logic [3:0] mask;
    case (sz)
      SZ_BYTE: mask = 4'b0001 << off;
      SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Store data is replicated across the word so the memory only has to
  // honour the byte enables.
  function automatic logic [31:0] replicate(input sizeT sz, input logic [31:0] data);
    logic [31:0] rep;
    case (sz)
      SZ_BYTE: rep = {4{data[7:0]}};
      SZ_HALF: rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter
//   Combinational lane extraction and sign/zero extension of read data.
//   Ports:
//     iRData   in  32  raw word returned by memory
//     iFunct3  in  3   load type (LB/LH/LW/LBU/LHU, others pass the word)
//     iByteOff in  2   byte offset of the access inside the word
//     oData    out 32  formatted load value
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] iRData,
  input  logic [2:0]  iFunct3,
  input  logic [1:0]  iByteOff,
  output logic [31:0] oData
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  assign byteLane = iRData[{iByteOff, 3'b000} +: 8];
  assign halfLane = iByteOff[1] ? iRData[31:16] : iRData[15:0];

  always_comb begin
    case (iFunct3)
      F3_LB:   oData = {{24{byteLane[7]}}, byteLane};
      F3_LH:   oData = {{16{halfLane[15]}}, halfLane};
      F3_LBU:  oData = {24'd0, byteLane};
      F3_LHU:  oData = {16'd0, halfLane};
      default: oData = iRData;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Bus front end for the multicycle core: turns the control FSM's
//   iMemRead/iMemWrite levels into single bus transactions, formats
//   store lanes and load data, and reports completion/timeouts.
//   Build option: define MISALIGN_TRAP_EN to trap misaligned data
//   accesses (adds port oMisaligned); otherwise misaligned low address
//   bits are forced to zero.
//   Ports:
//     iCLK, iRST                 clock, asynchronous active-high reset
//     iMemRead, iMemWrite        request levels from the control FSM
//     iIouD                      0: fetch from iPC, 1: data at iALUAddr
//     iPC, iALUAddr, iWriteData  fetch address, data address, store data
//     iFunct3                    data access size/sign
//     oBusAddr/WData/BE/Read/Write  memory request
//     iBusRData, iBusAck         memory response
//     oLoadData                  formatted read data (combinational)
//     oMDR                       registered formatted read data
//     oDone, oBusy, oBusErr      completion pulse, in-WAIT, sticky timeout
//     oMisaligned                sticky trap flag (MISALIGN_TRAP_EN only)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
)
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iIouD,
  input  logic [31:0] iPC,
  input  logic [31:0] iALUAddr,
  input  logic [31:0] iWriteData,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWData,
  output logic [3:0]  oBusBE,
  output logic        oBusRead,
  output logic        oBusWrite,
  input  logic [31:0] iBusRData,
  input  logic        iBusAck,
  output logic [31:0] oLoadData,
  output logic [31:0] oMDR,
  output logic        oDone,
  output logic        oBusy,
`ifdef MISALIGN_TRAP_EN
  output logic        oMisaligned,
`endif
  output logic        oBusErr
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  stateT stateReg, stateNext;

  logic reqLevel, reqPrev, needLow, reqEdge, start, trap, timeout;

  // Live request decode, used in the edge cycle and for capture.
  logic [31:0] rawAddr, liveAddr, liveWData;
  logic [2:0]  liveF3;
  sizeT        liveSize;
  logic        liveRead, liveWrite;
  logic [3:0]  liveBE;

  // Request held through WAIT.
  logic [31:0] addrReg, wdataReg, mdrReg, fmtData;
  logic [3:0]  beReg;
  logic [2:0]  f3Reg;
  logic        readReg, writeReg, errReg;
  logic [CNT_W-1:0] waitCnt;

  // A request starts only on a rising edge of the combined level. needLow
  // blocks a level that was already high through reset from counting as
  // an edge once reset is released.
  assign reqLevel = iMemRead | iMemWrite;
  assign reqEdge  = reqLevel & ~reqPrev & ~needLow;
  assign start    = (stateReg == ST_IDLE) & reqEdge & ~iRST;

  assign rawAddr   = iIouD ? iALUAddr : iPC;
  assign liveF3    = iIouD ? iFunct3 : F3_LW;
  assign liveSize  = accessSize(liveF3);
  assign liveRead  = iMemRead;
  assign liveWrite = iMemWrite & ~iMemRead;

`ifdef MISALIGN_TRAP_EN
  assign trap     = iIouD & isMisaligned(liveSize, rawAddr[1:0]);
  assign liveAddr = rawAddr;
`else
  assign trap     = 1'b0;
  assign liveAddr = iIouD ? {rawAddr[31:2], alignOffset(liveSize, rawAddr[1:0])} : rawAddr;
`endif

  assign liveBE    = laneMask(liveSize, liveAddr[1:0]);
  assign liveWData = liveWrite ? replicate(liveSize, iWriteData) : 32'd0;

  assign timeout = (stateReg == ST_WAIT) & ~iBusAck & (waitCnt == CNT_LAST);

  load_formatter uFormatter (
    .iRData   (iBusRData),
    .iFunct3  (f3Reg),
    .iByteOff (addrReg[1:0]),
    .oData    (fmtData)
  );

  // FSM: state register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) stateReg <= ST_IDLE;
    else      stateReg <= stateNext;
  end

  // FSM: next state.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE: if (start) stateNext = trap ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (iBusAck)      stateNext = ST_DONE;
        else if (timeout) stateNext = ST_IDLE;
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // FSM: outputs. The edge cycle drives the bus from the live inputs so a
  // synchronous memory can ack in the first WAIT cycle.
  always_comb begin
    oBusAddr  = 32'd0;
    oBusWData = 32'd0;
    oBusBE    = 4'd0;
    oBusRead  = 1'b0;
    oBusWrite = 1'b0;
    if (stateReg == ST_WAIT) begin
      oBusAddr  = addrReg;
      oBusWData = wdataReg;
      oBusBE    = beReg;
      oBusRead  = readReg;
      oBusWrite = writeReg;
    end else if (start && !trap) begin
      oBusAddr  = liveAddr;
      oBusWData = liveWData;
      oBusBE    = liveBE;
      oBusRead  = liveRead;
      oBusWrite = liveWrite;
    end
  end

  assign oDone     = (stateReg == ST_DONE);
  assign oBusy     = (stateReg == ST_WAIT);
  assign oMDR      = mdrReg;
  assign oBusErr   = errReg;
  assign oLoadData = iRST ? 32'd0 : fmtData;

  // Request capture, wait counter, MDR and sticky flags.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      reqPrev  <= 1'b0;
      needLow  <= 1'b1;
      addrReg  <= 32'd0;
      wdataReg <= 32'd0;
      beReg    <= 4'd0;
      f3Reg    <= 3'd0;
      readReg  <= 1'b0;
      writeReg <= 1'b0;
      waitCnt  <= '0;
      mdrReg   <= 32'd0;
      errReg   <= 1'b0;
    end else begin
      reqPrev <= reqLevel;
      if (!reqLevel) needLow <= 1'b0;

      if (start) begin
        addrReg  <= liveAddr;
        wdataReg <= liveWData;
        beReg    <= liveBE;
        f3Reg    <= liveF3;
        readReg  <= liveRead & ~trap;
        writeReg <= liveWrite & ~trap;
        waitCnt  <= '0;
        errReg   <= 1'b0;
      end else if (stateReg == ST_WAIT && !iBusAck) begin
        waitCnt <= waitCnt + CNT_W'(1);
      end

      if (timeout) errReg <= 1'b1;

      if (stateReg == ST_WAIT && iBusAck && readReg) mdrReg <= fmtData;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misReg;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)       misReg <= 1'b0;
    else if (start) misReg <= trap;
  end

  assign oMisaligned = misReg;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed and randomized transactions against an arithmetic reference
//   model of the bus request/response rules. Build option MISALIGN_TRAP_EN
//   adds the trap port and its directed case.
module tb_mem_access_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, iouD, busAck;
  logic [31:0] pc, aluAddr, wData, busRData;
  logic [2:0]  f3;
  logic [31:0] busAddr, busWData, loadData, mdr;
  logic [3:0]  busBE;
  logic        busRead, busWrite, done, busy, busErr;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] mdrModel = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .iCLK(clk), .iRST(rst),
    .iMemRead(memRead), .iMemWrite(memWrite), .iIouD(iouD),
    .iPC(pc), .iALUAddr(aluAddr), .iWriteData(wData), .iFunct3(f3),
    .oBusAddr(busAddr), .oBusWData(busWData), .oBusBE(busBE),
    .oBusRead(busRead), .oBusWrite(busWrite),
    .iBusRData(busRData), .iBusAck(busAck),
    .oLoadData(loadData), .oMDR(mdr), .oDone(done), .oBusy(busy),
`ifdef MISALIGN_TRAP_EN
    .oMisaligned(misaligned),
`endif
    .oBusErr(busErr)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int szOf(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] mdlBE(input int sz, input logic [1:0] off);
    if (sz == 1) return 4'b0001 << off;
    if (sz == 2) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] mdlWData(input int sz, input logic [31:0] wd);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] mdlLoad(input logic [2:0] f, input logic [1:0] off,
                                          input logic [31:0] rd);
    int sz;
    logic [31:0] mask, v;
    sz = szOf(f);
    if (sz == 4) return rd;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * off)) & mask;
    if (f < 3'd4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // One full transaction starting from IDLE with the request levels low.
  task automatic runTxn(input string tag, input logic rd, input logic wr, input logic iou,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input logic [2:0] f, input int ackDelay);
    logic        isRd, isWr;
    logic [2:0]  ef;
    int          sz;
    logic [31:0] ea, expLd;
    isRd  = rd;
    isWr  = wr & ~rd;
    ef    = iou ? f : 3'd2;
    sz    = szOf(ef);
    ea    = iou ? (a - (a % sz)) : a;
    expLd = mdlLoad(ef, ea[1:0], rdat);

    @(posedge clk); #1;
    memRead = rd; memWrite = wr; iouD = iou; f3 = f; wData = wd; busAck = 1'b0;
    if (iou) begin aluAddr = a; pc = $urandom; end
    else     begin pc = a; aluAddr = $urandom; end
    @(negedge clk);
    check({tag, ".edge_rd"}, 32'(busRead), 32'(isRd));
    check({tag, ".edge_wr"}, 32'(busWrite), 32'(isWr));
    check({tag, ".edge_addr"}, busAddr, ea);
    check({tag, ".edge_busy"}, 32'(busy), 32'd0);
    if (isWr || !iou) check({tag, ".edge_be"}, 32'(busBE), 32'(mdlBE(sz, ea[1:0])));
    if (isWr) check({tag, ".edge_wdata"}, busWData, mdlWData(sz, wd));

    for (int k = 0; k <= ackDelay; k++) begin
      @(posedge clk); #1;
      aluAddr = $urandom; pc = $urandom; wData = $urandom;
      f3 = 3'($urandom); iouD = 1'($urandom);
      busAck   = (k == ackDelay);
      busRData = (k == ackDelay) ? rdat : $urandom;
      @(negedge clk);
      check({tag, ".wait_busy"}, 32'(busy), 32'd1);
      check({tag, ".wait_rd"}, 32'(busRead), 32'(isRd));
      check({tag, ".wait_wr"}, 32'(busWrite), 32'(isWr));
      check({tag, ".wait_addr"}, busAddr, ea);
      if (isWr) check({tag, ".wait_wdata"}, busWData, mdlWData(sz, wd));
      if (isRd && k == ackDelay) check({tag, ".loaddata"}, loadData, expLd);
    end

    @(posedge clk); #1;
    busAck = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    if (isRd) mdrModel = expLd;
    @(negedge clk);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".done_busy"}, 32'(busy), 32'd0);
    check({tag, ".mdr"}, mdr, mdrModel);
    check({tag, ".done_rd"}, 32'(busRead), 32'd0);

    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".after_done"}, 32'(done), 32'd0);
    $display("[TB] txn %s rd=%0d wr=%0d iou=%0d f3=%0d addr=%h wd=%h rdata=%h ack=%0d mdr=%h",
             tag, rd, wr, iou, f, a, wd, rdat, ackDelay, mdr);
  endtask

  initial begin
    logic        rd, wr, iou;
    logic [2:0]  rf;
    logic [31:0] ra;
    int          kind;

    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; iouD = 1'b0;
    pc = '0; aluAddr = '0; wData = '0; f3 = '0; busRData = 32'hA5A5_A5A5; busAck = 1'b0;
    #2;
    check("rst.busread", 32'(busRead), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.mdr", mdr, 32'd0);
    check("rst.err", 32'(busErr), 32'd0);
    check("rst.loaddata", loadData, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fetch with ack in the first WAIT cycle.
    runTxn("fetch", 1'b1, 1'b0, 1'b0, 32'h0040_0010, 32'd0, 32'h0051_0513, 3'd7, 0);
    check("fetch.mdr_const", mdr, 32'h0051_0513);
    // LB / LBU on the top byte.
    runTxn("lb", 1'b1, 1'b0, 1'b1, 32'h0000_1003, 32'd0, 32'h80AA_BBCC, 3'd0, 0);
    check("lb.mdr_const", mdr, 32'hFFFF_FF80);
    runTxn("lbu", 1'b1, 1'b0, 1'b1, 32'h0000_1003, 32'd0, 32'h80AA_BBCC, 3'd4, 1);
    check("lbu.mdr_const", mdr, 32'h0000_0080);
    // SH on the upper half, ack late; write keeps the MDR.
    runTxn("sh", 1'b0, 1'b1, 1'b1, 32'h0000_1002, 32'h0000_1234, 32'hFFFF_FFFF, 3'd1, 3);
    check("sh.mdr_hold", mdr, 32'h0000_0080);
    // Read and write together: the read wins.
    runTxn("rdwr", 1'b1, 1'b1, 1'b1, 32'h0000_2006, 32'h1111_2222, 32'h8001_7FFF, 3'd5, 0);
`ifndef MISALIGN_TRAP_EN
    // Misaligned word forced onto the word boundary.
    runTxn("lw_mis", 1'b1, 1'b0, 1'b1, 32'h0000_1001, 32'd0, 32'hCAFE_F00D, 3'd2, 0);
`endif

    // Timeout: no ack for TO WAIT cycles.
    @(posedge clk); #1;
    memRead = 1'b1; iouD = 1'b1; aluAddr = 32'h0000_3000; f3 = 3'd2; busAck = 1'b0;
    @(negedge clk);
    check("to.edge_rd", 32'(busRead), 32'd1);
    for (int k = 0; k < TO; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("to.busy", 32'(busy), 32'd1);
      check("to.rd", 32'(busRead), 32'd1);
    end
    @(posedge clk); #1;
    memRead = 1'b0;
    @(negedge clk);
    check("to.idle_busy", 32'(busy), 32'd0);
    check("to.idle_rd", 32'(busRead), 32'd0);
    check("to.err", 32'(busErr), 32'd1);
    check("to.done", 32'(done), 32'd0);
    $display("[TB] txn timeout addr=00003000 err=%0d", busErr);
    runTxn("after_to", 1'b0, 1'b1, 1'b1, 32'h0000_3004, 32'hDEAD_BEEF, 32'd0, 3'd2, 0);
    check("after_to.err_clear", 32'(busErr), 32'd0);

    // Edge inside WAIT is ignored; a held level after DONE starts nothing.
    @(posedge clk); #1;
    memRead = 1'b1; iouD = 1'b0; pc = 32'h0000_0100;
    @(negedge clk);
    check("ign.edge_rd", 32'(busRead), 32'd1);
    @(posedge clk); #1;
    memRead = 1'b0;
    @(negedge clk);
    check("ign.w1_rd", 32'(busRead), 32'd1);
    @(posedge clk); #1;
    memRead = 1'b1; busAck = 1'b1; busRData = 32'h1357_9BDF;
    @(negedge clk);
    check("ign.w2_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    busAck = 1'b0; mdrModel = 32'h1357_9BDF;
    @(negedge clk);
    check("ign.done", 32'(done), 32'd1);
    check("ign.mdr", mdr, mdrModel);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("ign.idle_rd", 32'(busRead), 32'd0);
      check("ign.idle_busy", 32'(busy), 32'd0);
    end
    memRead = 1'b0;
    $display("[TB] txn ignored_edge pc=00000100 mdr=%h", mdr);

    // Reset in the second WAIT cycle.
    @(posedge clk); #1;
    memRead = 1'b1; iouD = 1'b1; aluAddr = 32'h0000_4000; f3 = 3'd2; busRData = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw.rd", 32'(busRead), 32'd0);
    check("rstw.addr", busAddr, 32'd0);
    check("rstw.be", 32'(busBE), 32'd0);
    check("rstw.busy", 32'(busy), 32'd0);
    check("rstw.mdr", mdr, 32'd0);
    check("rstw.loaddata", loadData, 32'd0);
    check("rstw.done", 32'(done), 32'd0);
    mdrModel = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstw.held_rd", 32'(busRead), 32'd0);
      check("rstw.held_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    memRead = 1'b0;
    $display("[TB] txn reset_mid_wait held_read_ignored busy=%0d", busy);

`ifdef MISALIGN_TRAP_EN
    @(posedge clk); #1;
    memRead = 1'b1; iouD = 1'b1; aluAddr = 32'h0000_1001; f3 = 3'd2;
    @(negedge clk);
    check("trap.rd", 32'(busRead), 32'd0);
    @(posedge clk); #1;
    memRead = 1'b0;
    @(negedge clk);
    check("trap.done", 32'(done), 32'd1);
    check("trap.flag", 32'(misaligned), 32'd1);
    check("trap.busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("trap.done_off", 32'(done), 32'd0);
    $display("[TB] txn trap addr=00001001 mis=%0d", misaligned);
    runTxn("after_trap", 1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'd0, 32'h0BAD_F00D, 3'd2, 0);
    check("after_trap.flag", 32'(misaligned), 32'd0);
`endif

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      ra   = $urandom;
      if (kind == 0) begin
        rd = 1'b1; wr = 1'b0; iou = 1'b0; rf = 3'($urandom);
      end else if (kind == 1) begin
        rd = 1'b1; wr = 1'($urandom_range(0, 4) == 0); iou = 1'b1; rf = 3'($urandom_range(0, 7));
      end else begin
        rd = 1'($urandom_range(0, 5) == 0); wr = 1'b1; iou = 1'b1; rf = 3'($urandom_range(0, 2));
      end
`ifdef MISALIGN_TRAP_EN
      if (iou) ra = ra - (ra % szOf(rf));
`endif
      runTxn($sformatf("rnd%0d", n), rd, wr, iou, ra, $urandom, $urandom, rf,
             $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
